// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_e    : operation codes carried on the 2-bit op port
//   mdu_state_e : control FSM states
//   op_is_div / op_is_signed : decode helpers for the op code
package mips_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Combinational per-lane conditional two's-complement negate.
//   data_i : LANES words of WIDTH bits
//   inv_i  : per-lane invert enable
//   inc_i  : per-lane increment (carry-in)
//   data_o : (inv ? ~data : data) + inc, per lane
// With inv=inc the lane is a plain conditional negate (used for abs()).
// Keeping inv and inc separate lets two lanes form one double-width
// negate: the upper lane only receives the +1 when the lower lane is zero.
module mdu_abs_neg #(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic [LANES-1:0][WIDTH-1:0] data_i,
  input  logic [LANES-1:0]            inv_i,
  input  logic [LANES-1:0]            inc_i,
  output logic [LANES-1:0][WIDTH-1:0] data_o
);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign data_o[gi] = (inv_i[gi] ? ~data_i[gi] : data_i[gi])
                        + {{(WIDTH-1){1'b0}}, inc_i[gi]};
    end
  endgenerate

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start, op           : launch MULT/MULTU/DIV/DIVU when idle
//   operand_a/operand_b : rs (multiplicand/dividend), rt (multiplier/divisor)
//   mthi, mtlo, mt_data : direct HI/LO writes, honoured only when idle
//   busy                : operation in progress (CALC or FIX)
//   done                : high during the FIX cycle; HI/LO update at its end
//   div_by_zero         : set at launch of a divide by zero, held until next start
//   hi, lo              : HI/LO registers
// Operands are made non-negative at launch, a W-step unsigned shift-add or
// restoring shift-subtract runs in CALC, and FIX restores the signs.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e           state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q;      // product, or quotient in the low half
  logic [WIDTH:0]       rem_q;      // partial remainder
  logic [WIDTH-1:0]     opnd_q;     // |multiplicand| or |divisor|
  logic [CW-1:0]        count_q;
  logic                 is_div_q;
  logic                 neg_quo_q;  // negate product / quotient at FIX
  logic                 neg_rem_q;  // negate remainder at FIX
  logic                 dz_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  // ---------------- launch-time decode and operand abs ----------------
  logic                  start_signed, start_div, start_dz;
  logic                  a_neg, b_neg;
  logic [1:0][WIDTH-1:0] abs_ops;

  assign start_signed = op_is_signed(op);
  assign start_div    = op_is_div(op);
  assign start_dz     = start_div && (operand_b == '0);
  assign a_neg        = start_signed & operand_a[WIDTH-1];
  assign b_neg        = start_signed & operand_b[WIDTH-1];

  // |0x80..0| yields 0x80..0, which is the correct unsigned magnitude.
  mdu_abs_neg #(.WIDTH(WIDTH), .LANES(2)) u_abs (
    .data_i ({operand_b, operand_a}),
    .inv_i  ({b_neg, a_neg}),
    .inc_i  ({b_neg, a_neg}),
    .data_o (abs_ops)
  );

  // ---------------- iteration step ----------------
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc_d;
  logic [WIDTH+1:0]     div_shift, div_diff;
  logic                 div_ok;
  logic [WIDTH:0]       div_rem_d;
  logic [WIDTH-1:0]     div_quo_d;

  // Multiply: multiplier sits in the low half and is consumed LSB first
  // while the product grows into the high half.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: shift the next dividend bit into the remainder; a non-negative
  // trial difference means the quotient bit is 1 and the difference is kept.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, opnd_q};
  assign div_ok    = ~div_diff[WIDTH+1];
  assign div_rem_d = div_ok ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
  assign div_quo_d = {acc_q[WIDTH-2:0], div_ok};

  // ---------------- result sign fix ----------------
  // Lane 0 is LO (product low / quotient), lane 1 is HI (product high /
  // remainder). For a product the two lanes chain into one 2W negate.
  logic [1:0][WIDTH-1:0] fix_in, fix_out;
  logic [1:0]            fix_inv, fix_inc;

  always_comb begin
    fix_in[0]  = acc_q[WIDTH-1:0];
    fix_inv[0] = neg_quo_q;
    fix_inc[0] = neg_quo_q;
    if (is_div_q) begin
      fix_in[1]  = rem_q[WIDTH-1:0];
      fix_inv[1] = neg_rem_q;
      fix_inc[1] = neg_rem_q;
    end else begin
      fix_in[1]  = acc_q[2*WIDTH-1:WIDTH];
      fix_inv[1] = neg_quo_q;
      fix_inc[1] = neg_quo_q & (acc_q[WIDTH-1:0] == '0);
    end
  end

  mdu_abs_neg #(.WIDTH(WIDTH), .LANES(2)) u_fix (
    .data_i (fix_in),
    .inv_i  (fix_inv),
    .inc_i  (fix_inc),
    .data_o (fix_out)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (start) state_d = start_dz ? MDU_FIX : MDU_CALC;
      MDU_CALC: if (count_q == '0) state_d = MDU_FIX;
      MDU_FIX:  state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q != MDU_IDLE);
    done = (state_q == MDU_FIX);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            is_div_q  <= start_div;
            dz_q      <= start_dz;
            count_q   <= CW'(WIDTH-1);
            opnd_q    <= start_div ? abs_ops[1] : abs_ops[0];
            if (start_dz) begin
              // Reuse the divide FIX path: HI <- raw dividend, LO <- all ones.
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              acc_q     <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              rem_q     <= {1'b0, operand_a};
            end else begin
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= start_div & a_neg;  // remainder follows dividend
              acc_q     <= {{WIDTH{1'b0}}, start_div ? abs_ops[0] : abs_ops[1]};
              rem_q     <= '0;
            end
          end else begin
            if (mthi) hi_q <= mt_data;
            if (mtlo) lo_q <= mt_data;
          end
        end
        MDU_CALC: begin
          count_q <= count_q - 1'b1;
          if (is_div_q) begin
            rem_q              <= div_rem_d;
            acc_q[WIDTH-1:0]   <= div_quo_d;
          end else begin
            acc_q <= mul_acc_d;
          end
        end
        MDU_FIX: begin
          lo_q <= fix_out[0];
          hi_q <= fix_out[1];
        end
        default: ;
      endcase
    end
  end

  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        mthi, mtlo;
  logic [31:0] mt_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  int n;
  int done_seen;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .mt_data     (mt_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge (E0) and return 1 time unit after it.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done is seen high (bounded).
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    mthi = 1'b0; mtlo = 1'b0; mt_data = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz",   64'(div_by_zero), 64'd0);
    chk("rst_hi",   64'(hi), 64'd0);
    chk("rst_lo",   64'(lo), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    $display("reset checked");

    // MULTU max*max, full latency
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("t1_busy_e1", 64'(busy), 64'd1);
    chk("t1_done_e1", 64'(done), 64'd0);
    tick();
    chk("t1_hi_hold", 64'(hi), 64'd0);
    wait_done(n);
    chk("t1_latency", 64'(n + 1), 64'd32);
    chk("t1_busy_fix", 64'(busy), 64'd1);
    tick();
    chk("t1_hi", 64'(hi), 64'hFFFFFFFE);
    chk("t1_lo", 64'(lo), 64'h00000001);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_done_end", 64'(done), 64'd0);
    $display("MULTU ffffffff*ffffffff -> hi=%h lo=%h", hi, lo);

    // MULT -3*7
    launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
    wait_done(n); chk("t2_latency", 64'(n), 64'd32); tick();
    chk("t2_hi", 64'(hi), 64'hFFFFFFFF);
    chk("t2_lo", 64'(lo), 64'hFFFFFFEB);
    $display("MULT -3*7 -> hi=%h lo=%h", hi, lo);

    // DIV -7/2
    launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n); chk("t3a_latency", 64'(n), 64'd32); tick();
    chk("t3a_lo", 64'(lo), 64'hFFFFFFFD);
    chk("t3a_hi", 64'(hi), 64'hFFFFFFFF);
    $display("DIV -7/2 -> hi=%h lo=%h", hi, lo);

    // DIV min/-1
    launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n); chk("t3b_latency", 64'(n), 64'd32); tick();
    chk("t3b_lo", 64'(lo), 64'h80000000);
    chk("t3b_hi", 64'(hi), 64'h00000000);
    $display("DIV 80000000/ffffffff -> hi=%h lo=%h", hi, lo);

    // DIV 7/-2: quotient -3, remainder +1
    launch(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done(n); chk("t3c_latency", 64'(n), 64'd32); tick();
    chk("t3c_lo", 64'(lo), 64'hFFFFFFFD);
    chk("t3c_hi", 64'(hi), 64'h00000001);
    $display("DIV 7/-2 -> hi=%h lo=%h", hi, lo);

    // DIVU 100/7: 14 r 2
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(n); chk("t3d_latency", 64'(n), 64'd32); tick();
    chk("t3d_lo", 64'(lo), 64'd14);
    chk("t3d_hi", 64'(hi), 64'd2);
    $display("DIVU 100/7 -> hi=%h lo=%h", hi, lo);

    // MULT -5*-6 = 30
    launch(OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA);
    wait_done(n); tick();
    chk("t3e_hi", 64'(hi), 64'd0);
    chk("t3e_lo", 64'(lo), 64'd30);
    $display("MULT -5*-6 -> hi=%h lo=%h", hi, lo);

    // DIVU 100/0: done right after E0
    launch(OP_DIVU, 32'd100, 32'd0);
    chk("t4_done_e0", 64'(done), 64'd1);
    chk("t4_dz_e0",   64'(div_by_zero), 64'd1);
    tick();
    chk("t4_hi",   64'(hi), 64'h00000064);
    chk("t4_lo",   64'(lo), 64'hFFFFFFFF);
    chk("t4_dz",   64'(div_by_zero), 64'd1);
    chk("t4_done", 64'(done), 64'd0);
    $display("DIVU 100/0 -> hi=%h lo=%h dz=%b", hi, lo, div_by_zero);

    launch(OP_MULTU, 32'd2, 32'd3);
    chk("t4b_dz_clr", 64'(div_by_zero), 64'd0);
    wait_done(n); tick();
    chk("t4b_hi", 64'(hi), 64'd0);
    chk("t4b_lo", 64'(lo), 64'd6);
    $display("MULTU 2*3 -> hi=%h lo=%h", hi, lo);

    // start and mtlo during busy are ignored
    launch(OP_MULTU, 32'd5, 32'd6);
    repeat (9) tick();
    op = OP_DIVU; operand_a = 32'd9; operand_b = 32'd3; start = 1'b1;
    mtlo = 1'b1; mt_data = 32'hCAFEBABE;
    tick();
    start = 1'b0; mtlo = 1'b0;
    chk("t5_lo_busy", 64'(lo), 64'd6);
    wait_done(n);
    chk("t5_latency", 64'(n), 64'd22);
    tick();
    chk("t5_hi", 64'(hi), 64'd0);
    chk("t5_lo", 64'(lo), 64'h1E);
    tick();
    chk("t5_idle", 64'(busy), 64'd0);
    $display("MULTU 5*6 with ignored start/mtlo -> hi=%h lo=%h", hi, lo);

    // mthi while idle
    mthi = 1'b1; mt_data = 32'hDEADBEEF;
    tick();
    mthi = 1'b0;
    chk("t5_mthi_hi", 64'(hi), 64'hDEADBEEF);
    chk("t5_mthi_lo", 64'(lo), 64'h1E);
    $display("MTHI deadbeef -> hi=%h lo=%h", hi, lo);

    // start wins over mtlo in the same idle cycle
    mtlo = 1'b1; mt_data = 32'h12345678;
    launch(OP_MULTU, 32'd1, 32'd1);
    mtlo = 1'b0;
    chk("t5_sw_lo", 64'(lo), 64'h1E);
    wait_done(n); tick();
    chk("t5_sw_hi_r", 64'(hi), 64'd0);
    chk("t5_sw_lo_r", 64'(lo), 64'd1);
    $display("MULTU 1*1 with mtlo -> hi=%h lo=%h", hi, lo);

    // mthi and mtlo together
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h55AA55AA;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("t5_mt2_hi", 64'(hi), 64'h55AA55AA);
    chk("t5_mt2_lo", 64'(lo), 64'h55AA55AA);
    $display("MTHI+MTLO 55aa55aa -> hi=%h lo=%h", hi, lo);

    // start asserted on the done cycle is ignored
    launch(OP_MULT, 32'hFFFFFFFB, 32'd6);
    wait_done(n);
    op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_dc_busy", 64'(busy), 64'd0);
    chk("t5_dc_hi", 64'(hi), 64'hFFFFFFFF);
    chk("t5_dc_lo", 64'(lo), 64'hFFFFFFE2);
    tick();
    chk("t5_dc_busy2", 64'(busy), 64'd0);
    $display("MULT -5*6 with start on done -> hi=%h lo=%h", hi, lo);

    // reset mid-operation
    launch(OP_MULTU, 32'd7, 32'd7);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_hi",   64'(hi), 64'd0);
    chk("t6_lo",   64'(lo), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    chk("t6_no_done", 64'(done_seen), 64'd0);
    chk("t6_lo_end", 64'(lo), 64'd0);
    $display("reset mid-op -> busy=%b hi=%h lo=%h", busy, hi, lo);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
